// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Holds the state enum, opcode/funct constants, ALU codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_WB,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SGT  = 4'b1001;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational opcode/funct -> ALU operation and instruction-valid decode.
// Zero latency; no flow control.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_NONE;
    valid  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_JR:   alu_op = ALU_NONE;
          default: valid  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_BEQ, OP_BNE:        alu_op = ALU_SUB;
      OP_ANDI:               alu_op = ALU_AND;
      OP_ORI:                alu_op = ALU_OR;
      OP_XORI:               alu_op = ALU_XOR;
      OP_SLTI:               alu_op = ALU_SLT;
      OP_J, OP_JAL:          alu_op = ALU_NONE;
      default:               valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback on a shared datapath.
// 3-5 cycles per instruction plus memory waits; stalls on mem_ready, traps after MEM_TIMEOUT cycles.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W         = 4,
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_INVALID = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr_en,
  output logic [1:0]         pc_src,
  output logic               iord,
  output logic               ir_wr_en,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic               reg_wr_en,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               invalid_inst,
  output logic               bus_error,
  output logic               trapped
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, next_state;
  logic [5:0]    op_q, fn_q;
  logic [CW-1:0] wait_cnt;
  logic          bus_err_q, inval_q;
  logic [5:0]    dec_opcode, dec_funct;
  logic [3:0]    dec_alu_op, alu_op_c;
  logic          dec_valid;
  logic          mem_wait, timeout;

  // Decode the live IR during S_DECODE, the latched copy afterwards.
  assign dec_opcode = (state == S_DECODE) ? opcode : op_q;
  assign dec_funct  = (state == S_DECODE) ? funct  : fn_q;

  mc_alu_decode u_alu_decode (
    .opcode (dec_opcode),
    .funct  (dec_funct),
    .alu_op (dec_alu_op),
    .valid  (dec_valid)
  );

  assign mem_wait = is_mem_wait(state);
  // A ready arriving on the last allowed cycle still completes the access.
  assign timeout  = mem_wait && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    next_state = state;
    pc_wr_en   = 1'b0;
    pc_src     = PC_ALU;
    iord       = 1'b0;
    ir_wr_en   = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    reg_wr_en  = 1'b0;
    reg_dst    = DST_RT;
    wb_src     = WB_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RT;
    alu_op_c   = ALU_NONE;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_rd_en = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op_c  = ALU_ADD;
        if (mem_ready) begin
          ir_wr_en   = 1'b1;
          pc_wr_en   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op_c  = ALU_ADD;
        if (!dec_valid) begin
          next_state = TRAP_ON_INVALID ? S_TRAP : S_FETCH;
        end else begin
          case (opcode)
            OP_RTYPE:                                 next_state = (funct == FN_JR) ? S_JR : S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: next_state = S_EXEC_I;
            OP_LW, OP_SW:                             next_state = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                           next_state = S_BRANCH;
            OP_J, OP_JAL:                             next_state = S_JUMP;
            default:                                  next_state = S_TRAP;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_src_a  = ((fn_q == FN_SLL) || (fn_q == FN_SRL)) ? SRCA_SHAMT : SRCA_RS;
        alu_op_c   = dec_alu_op;
        next_state = S_WB_R;
      end
      S_WB_R: begin
        reg_wr_en  = 1'b1;
        reg_dst    = DST_RD;
        next_state = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS;
        alu_src_b  = SRCB_IMM;
        alu_op_c   = dec_alu_op;
        next_state = S_WB_I;
      end
      S_WB_I: begin
        reg_wr_en  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = SRCA_RS;
        alu_src_b  = SRCB_IMM;
        alu_op_c   = ALU_ADD;
        next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord      = 1'b1;
        mem_rd_en = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_wr_en = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_MEM_WB: begin
        reg_wr_en  = 1'b1;
        wb_src     = WB_MDR;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS;
        alu_op_c   = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_wr_en   = (op_q == OP_BEQ) ? zero : ~zero;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_wr_en = 1'b1;
        if (op_q == OP_JAL) begin
          reg_wr_en = 1'b1;
          reg_dst   = DST_RA;
          wb_src    = WB_PC;
        end
        next_state = S_FETCH;
      end
      S_JR: begin
        pc_src     = PC_RS;
        pc_wr_en   = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_IDLE;
    endcase
    if (timeout) next_state = S_TRAP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      fn_q      <= '0;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
      inval_q   <= 1'b0;
    end else begin
      if (state == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      // Leaving or never being in a wait state zeroes the count, so every wait starts at 0.
      if (mem_wait && !mem_ready && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                    wait_cnt <= '0;
      if (timeout) bus_err_q <= 1'b1;
      inval_q <= (state == S_DECODE) && !dec_valid;
    end
  end

  assign alu_op       = ALUOP_W'(alu_op_c);
  assign invalid_inst = inval_q;
  assign bus_error    = bus_err_q;
  assign trapped      = (state == S_TRAP);

endmodule
